// File: rtl/cov_readout.sv
// Purpose : snapshot all coverage hit counters on request, stream (index, count) per point,
//           then publish covered / covered-condition totals; also issues the instrumentation clear strobe.
// Latency : start at cycle T -> first beat at T+2; done at T+2+beats (full-rate consumer).
//           Backpressure: valid/ready; a stalled beat holds every stream output stable until accepted.
//
// Ports:
//   clock, reset (async, active-low)
//   cnt_vec / is_cond_vec   : live counters (point i at [i*CNT_W +: CNT_W]) and condition-point flags
//   start / clear_req       : readout request (IDLE only) and instrumentation-clear request
//   busy                    : readout in progress (SNAP/STREAM/DONE)
//   out_valid/out_ready/out_idx/out_count/out_covered/out_last : beat stream
//   done / total_covered / cond_covered : one-cycle summary strobe and held totals
//   clear_pulse             : one-cycle clear strobe to the instrumentation
//
// Build option: COV_READOUT_SKIP_MISSED_EN -- when defined, points whose snapshot count is zero
// emit no beat and cost no cycle; totals are unaffected.

module cov_readout #(
    parameter int NUM_POINTS = 13,
    parameter int CNT_W      = 32,
    parameter int IDX_W      = $clog2(NUM_POINTS),
    parameter int TOT_W      = $clog2(NUM_POINTS + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_POINTS*CNT_W-1:0] cnt_vec,
    input  logic [NUM_POINTS-1:0]       is_cond_vec,
    input  logic                        start,
    input  logic                        clear_req,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            out_idx,
    output logic [CNT_W-1:0]            out_count,
    output logic                        out_covered,
    output logic                        out_last,
    output logic                        done,
    output logic [TOT_W-1:0]            total_covered,
    output logic [TOT_W-1:0]            cond_covered,
    output logic                        clear_pulse
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SNAP   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [NUM_POINTS*CNT_W-1:0]   snap_cnt_q, snap_cnt_d;
    logic [NUM_POINTS-1:0]         snap_cond_q, snap_cond_d;
    logic [TOT_W-1:0]              acc_tot_q, acc_tot_d;
    logic [TOT_W-1:0]              acc_cond_q, acc_cond_d;
    logic                          clear_pend_q, clear_pend_d;

    logic                          valid_d;
    logic [IDX_W-1:0]              idx_d;
    logic [CNT_W-1:0]              count_d;
    logic                          covered_d;
    logic                          last_d;
    logic [TOT_W-1:0]              total_d;
    logic [TOT_W-1:0]              cond_d;
    logic                          pulse_d;

    // Points eligible to produce a beat: every point normally, only non-zero
    // counts when missed points are skipped. live_mask looks at cnt_vec so the
    // first beat can be loaded in the same edge that takes the snapshot.
    logic [NUM_POINTS-1:0]         live_mask;
    logic [NUM_POINTS-1:0]         snap_mask;

    // Beat-load request shared by SNAP (from live counters) and STREAM (from snapshot)
    logic                          ld_en;
    int                            ld_pos;
    logic [NUM_POINTS*CNT_W-1:0]   ld_vec;
    logic [NUM_POINTS-1:0]         ld_mask;

    // Lowest eligible point at or above 'from'; -1 when none.
    function automatic int first_from(input logic [NUM_POINTS-1:0] mask, input int from);
        int r;
        r = -1;
        for (int i = NUM_POINTS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) r = i;
        end
        return r;
    endfunction

    // True when no eligible point lies above position j (beat j is the final one).
    function automatic logic none_above(input logic [NUM_POINTS-1:0] mask, input int j);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NUM_POINTS; i++) begin
            if (mask[i] && (i > j)) r = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_at(input logic [NUM_POINTS*CNT_W-1:0] v, input int i);
        return v[i*CNT_W +: CNT_W];
    endfunction

    always_comb begin
        live_mask = '1;
        snap_mask = '1;
`ifdef COV_READOUT_SKIP_MISSED_EN
        for (int i = 0; i < NUM_POINTS; i++) begin
            live_mask[i] = |cnt_vec[i*CNT_W +: CNT_W];
            snap_mask[i] = |snap_cnt_q[i*CNT_W +: CNT_W];
        end
`endif
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    always_comb begin
        state_d      = state_q;
        snap_cnt_d   = snap_cnt_q;
        snap_cond_d  = snap_cond_q;
        acc_tot_d    = acc_tot_q;
        acc_cond_d   = acc_cond_q;
        clear_pend_d = clear_pend_q;
        valid_d      = out_valid;
        idx_d        = out_idx;
        count_d      = out_count;
        covered_d    = out_covered;
        last_d       = out_last;
        total_d      = total_covered;
        cond_d       = cond_covered;
        pulse_d      = 1'b0;
        ld_en        = 1'b0;
        ld_pos       = 0;
        ld_vec       = snap_cnt_q;
        ld_mask      = snap_mask;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_SNAP;
                    acc_tot_d    = '0;
                    acc_cond_d   = '0;
                    // a clear coincident with an accepted start waits for the readout to finish
                    clear_pend_d = clear_pend_q | clear_req;
                end else if (clear_req) begin
                    pulse_d = 1'b1;
                end
            end

            S_SNAP: begin
                clear_pend_d = clear_pend_q | clear_req;
                snap_cnt_d   = cnt_vec;
                snap_cond_d  = is_cond_vec;
                ld_vec       = cnt_vec;
                ld_mask      = live_mask;
                ld_pos       = first_from(live_mask, 0);
                ld_en        = (ld_pos >= 0);
                valid_d      = (ld_pos >= 0);
                state_d      = S_STREAM;
            end

            S_STREAM: begin
                clear_pend_d = clear_pend_q | clear_req;
                if (!out_valid) begin
                    // nothing eligible to stream (skip mode, all counts zero)
                    state_d = S_DONE;
                    total_d = acc_tot_q;
                    cond_d  = acc_cond_q;
                end else if (out_ready) begin
                    acc_tot_d  = acc_tot_q + TOT_W'(out_covered);
                    acc_cond_d = acc_cond_q + TOT_W'(out_covered & snap_cond_q[out_idx]);
                    if (out_last) begin
                        valid_d = 1'b0;
                        state_d = S_DONE;
                        total_d = acc_tot_d;
                        cond_d  = acc_cond_d;
                    end else begin
                        ld_pos = first_from(snap_mask, int'(out_idx) + 1);
                        ld_en  = (ld_pos >= 0);
                    end
                end
            end

            S_DONE: begin
                // all clear requests seen during the readout merge into one strobe
                pulse_d      = clear_pend_q | clear_req;
                clear_pend_d = 1'b0;
                state_d      = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        if (ld_en) begin
            idx_d     = IDX_W'(ld_pos);
            count_d   = cnt_at(ld_vec, ld_pos);
            covered_d = |count_d;
            last_d    = none_above(ld_mask, ld_pos);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            snap_cnt_q    <= '0;
            snap_cond_q   <= '0;
            acc_tot_q     <= '0;
            acc_cond_q    <= '0;
            clear_pend_q  <= 1'b0;
            out_valid     <= 1'b0;
            out_idx       <= '0;
            out_count     <= '0;
            out_covered   <= 1'b0;
            out_last      <= 1'b0;
            total_covered <= '0;
            cond_covered  <= '0;
            clear_pulse   <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_cnt_q    <= snap_cnt_d;
            snap_cond_q   <= snap_cond_d;
            acc_tot_q     <= acc_tot_d;
            acc_cond_q    <= acc_cond_d;
            clear_pend_q  <= clear_pend_d;
            out_valid     <= valid_d;
            out_idx       <= idx_d;
            out_count     <= count_d;
            out_covered   <= covered_d;
            out_last      <= last_d;
            total_covered <= total_d;
            cond_covered  <= cond_d;
            clear_pulse   <= pulse_d;
        end
    end

endmodule

// File: tb/tb_cov_readout.sv
// Directed bench for cov_readout: full-rate readout, stalled readout, clear handling,
// ignored starts, mid-stream reset. Expected beats follow the build's skip option.

module tb_cov_readout;

    localparam int NP = 13;
    localparam int CW = 32;
    localparam int IW = $clog2(NP);
    localparam int TW = $clog2(NP + 1);

    logic               clock;
    logic               reset;
    logic [NP*CW-1:0]   cnt_vec;
    logic [NP-1:0]      is_cond_vec;
    logic               start;
    logic               clear_req;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [IW-1:0]      out_idx;
    logic [CW-1:0]      out_count;
    logic               out_covered;
    logic               out_last;
    logic               done;
    logic [TW-1:0]      total_covered;
    logic [TW-1:0]      cond_covered;
    logic               clear_pulse;

    cov_readout #(.NUM_POINTS(NP), .CNT_W(CW)) dut (
        .clock         (clock),
        .reset         (reset),
        .cnt_vec       (cnt_vec),
        .is_cond_vec   (is_cond_vec),
        .start         (start),
        .clear_req     (clear_req),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_idx       (out_idx),
        .out_count     (out_count),
        .out_covered   (out_covered),
        .out_last      (out_last),
        .done          (done),
        .total_covered (total_covered),
        .cond_covered  (cond_covered),
        .clear_pulse   (clear_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    int cnts[NP];
    int e_idx[$];
    int b_idx[$];
    int b_cnt[$];
    int b_cov[$];
    int b_last[$];
    int done_cyc, done_n, clr_n, clr_first, stall_bad;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive counters from cnts[] and derive the expected beat index list.
    task automatic load_counts();
        e_idx.delete();
        for (int i = 0; i < NP; i++) begin
            cnt_vec[i*CW +: CW] = CW'(cnts[i]);
`ifdef COV_READOUT_SKIP_MISSED_EN
            if (cnts[i] != 0) e_idx.push_back(i);
`else
            e_idx.push_back(i);
`endif
        end
    endtask

    function automatic int exp_done_full();
        return (e_idx.size() == 0) ? 3 : 2 + e_idx.size();
    endfunction

    // Start pulse at cycle 0, then record beats, done and clear_pulse activity.
    // rdy_mode 0: ready always 1; 1: ready 1,0,0,1 repeating.
    task automatic run_readout(input int rdy_mode, input int clr_beat, input bit extra_start, input bit mod_cnt);
        logic [3:0]    pat;
        logic [IW-1:0] p_idx;
        logic [CW-1:0] p_cnt;
        logic          p_cov, p_last;
        bit            prev_stall;
        pat = 4'b1001;
        prev_stall = 1'b0;
        p_idx = '0; p_cnt = '0; p_cov = 1'b0; p_last = 1'b0;
        b_idx.delete(); b_cnt.delete(); b_cov.delete(); b_last.delete();
        done_cyc = -1; done_n = 0; clr_n = 0; clr_first = -1; stall_bad = 0;
        out_ready = 1'b1;
        clear_req = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            step();
            start = 1'b0;
            clear_req = 1'b0;
            if (mod_cnt && c == 2) cnt_vec = ~cnt_vec;
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
                if (extra_start) start = 1'b1;
            end
            if (clear_pulse) begin
                clr_n++;
                if (clr_first < 0) clr_first = c;
            end
            if (prev_stall && (!out_valid || out_idx !== p_idx || out_count !== p_cnt ||
                               out_covered !== p_cov || out_last !== p_last))
                stall_bad++;
            out_ready = (rdy_mode == 0) ? 1'b1 : pat[c % 4];
            if (out_valid) begin
                if (clr_beat == b_idx.size()) clear_req = 1'b1;
                if (extra_start && b_idx.size() == 3) start = 1'b1;
                if (out_ready) begin
                    b_idx.push_back(int'(out_idx));
                    b_cnt.push_back(int'(out_count));
                    b_cov.push_back(int'(out_covered));
                    b_last.push_back(int'(out_last));
                end
            end
            prev_stall = out_valid && !out_ready;
            p_idx = out_idx; p_cnt = out_count; p_cov = out_covered; p_last = out_last;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        start = 1'b0;
        clear_req = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %0b want 0", done); end
        checks++; if (total_covered !== '0) begin failures++; $display("FAIL rst_total: got %0d want 0", total_covered); end
        checks++; if (cond_covered !== '0) begin failures++; $display("FAIL rst_cond: got %0d want 0", cond_covered); end
        checks++; if (clear_pulse !== 1'b0) begin failures++; $display("FAIL rst_clr: got %0b want 0", clear_pulse); end
        step(); step();
        reset = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_basic();
        cnts = '{5, 0, 3, 0, 1, 1, 0, 2, 7, 0, 4, 0, 9};
        load_counts();
        run_readout(0, -1, 1'b0, 1'b0);
        checks++; if (b_idx.size() !== e_idx.size()) begin failures++; $display("FAIL basic_nbeats: got %0d want %0d", b_idx.size(), e_idx.size()); end
        for (int k = 0; k < b_idx.size() && k < e_idx.size(); k++) begin
            checks++;
            if (b_idx[k] !== e_idx[k] || b_cnt[k] !== cnts[e_idx[k]] || b_cov[k] !== int'(cnts[e_idx[k]] != 0) ||
                b_last[k] !== int'(k == e_idx.size() - 1)) begin
                failures++;
                $display("FAIL basic_beat%0d: got idx=%0d cnt=%0d cov=%0d last=%0d want idx=%0d cnt=%0d last=%0d",
                         k, b_idx[k], b_cnt[k], b_cov[k], b_last[k], e_idx[k], cnts[e_idx[k]], int'(k == e_idx.size() - 1));
            end
        end
        checks++; if (done_cyc !== exp_done_full()) begin failures++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, exp_done_full()); end
        checks++; if (done_n !== 1) begin failures++; $display("FAIL basic_done_n: got %0d want 1", done_n); end
        checks++; if (total_covered !== TW'(8)) begin failures++; $display("FAIL basic_total: got %0d want 8", total_covered); end
        checks++; if (cond_covered !== TW'(3)) begin failures++; $display("FAIL basic_cond: got %0d want 3", cond_covered); end
        checks++; if (clr_n !== 0) begin failures++; $display("FAIL basic_no_clr: got %0d pulses want 0", clr_n); end
    endtask

    task automatic test_idle_clear();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        checks++; if (clear_pulse !== 1'b1) begin failures++; $display("FAIL idle_clr_pulse: got %0b want 1", clear_pulse); end
        checks++; if (total_covered !== TW'(8)) begin failures++; $display("FAIL idle_clr_total: got %0d want 8", total_covered); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_clr_busy: got %0b want 0", busy); end
        step();
        checks++; if (clear_pulse !== 1'b0) begin failures++; $display("FAIL idle_clr_single: got %0b want 0", clear_pulse); end
    endtask

    task automatic test_stall();
        int n, lastc;
        load_counts();
        run_readout(1, -1, 1'b0, 1'b1);
        // ready high only on cycles with c%4 in {0,3}: beats 2k,2k+1 transfer at 4k+3, 4k+4
        n = e_idx.size();
        lastc = 4 * ((n - 1) / 2) + (((n - 1) % 2 == 0) ? 3 : 4);
        checks++; if (stall_bad !== 0) begin failures++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stall_bad); end
        checks++; if (b_idx.size() !== n) begin failures++; $display("FAIL stall_nbeats: got %0d want %0d", b_idx.size(), n); end
        for (int k = 0; k < b_idx.size() && k < n; k++) begin
            checks++;
            if (b_idx[k] !== e_idx[k] || b_cnt[k] !== cnts[e_idx[k]] || b_last[k] !== int'(k == n - 1)) begin
                failures++;
                $display("FAIL stall_beat%0d: got idx=%0d cnt=%0d last=%0d want idx=%0d cnt=%0d",
                         k, b_idx[k], b_cnt[k], b_last[k], e_idx[k], cnts[e_idx[k]]);
            end
        end
        checks++; if (done_cyc !== lastc + 1) begin failures++; $display("FAIL stall_done_cyc: got %0d want %0d", done_cyc, lastc + 1); end
        checks++; if (total_covered !== TW'(8)) begin failures++; $display("FAIL stall_total: got %0d want 8", total_covered); end
        checks++; if (cond_covered !== TW'(3)) begin failures++; $display("FAIL stall_cond: got %0d want 3", cond_covered); end
    endtask

    task automatic test_ignore_start();
        load_counts();
        run_readout(0, -1, 1'b1, 1'b0);
        checks++; if (b_idx.size() !== e_idx.size()) begin failures++; $display("FAIL ign_nbeats: got %0d want %0d", b_idx.size(), e_idx.size()); end
        for (int k = 0; k < b_idx.size() && k < e_idx.size(); k++) begin
            checks++;
            if (b_idx[k] !== e_idx[k] || b_cnt[k] !== cnts[e_idx[k]]) begin
                failures++;
                $display("FAIL ign_beat%0d: got idx=%0d cnt=%0d want idx=%0d cnt=%0d", k, b_idx[k], b_cnt[k], e_idx[k], cnts[e_idx[k]]);
            end
        end
        checks++; if (done_n !== 1) begin failures++; $display("FAIL ign_done_n: got %0d want 1", done_n); end
        checks++; if (done_cyc !== exp_done_full()) begin failures++; $display("FAIL ign_done_cyc: got %0d want %0d", done_cyc, exp_done_full()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_not_queued: busy=%0b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int  nb;
        bit  hit;
        load_counts();
        nb = 0;
        hit = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            start = 1'b0;
            clear_req = 1'b0;
            if (out_valid) begin
                if (nb == 6) begin hit = 1'b1; break; end
                if (nb == 3) clear_req = 1'b1;
                nb++;
            end
        end
        checks++; if (!hit) begin failures++; $display("FAIL rmid_reach_beat6: got %0d beats want 6", nb); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %0b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %0b want 0", busy); end
        checks++; if (total_covered !== '0) begin failures++; $display("FAIL rmid_total: got %0d want 0", total_covered); end
        checks++; if (cond_covered !== '0) begin failures++; $display("FAIL rmid_cond: got %0d want 0", cond_covered); end
        checks++; if (clear_pulse !== 1'b0) begin failures++; $display("FAIL rmid_clr: got %0b want 0", clear_pulse); end
        step(); step();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (clear_pulse !== 1'b0) begin failures++; $display("FAIL rmid_pend_lost%0d: clear_pulse=%0b want 0", c, clear_pulse); end
        end
        run_readout(0, -1, 1'b0, 1'b0);
        checks++; if (b_idx.size() !== e_idx.size()) begin failures++; $display("FAIL rmid_nbeats: got %0d want %0d", b_idx.size(), e_idx.size()); end
        for (int k = 0; k < b_idx.size() && k < e_idx.size(); k++) begin
            checks++;
            if (b_idx[k] !== e_idx[k] || b_cnt[k] !== cnts[e_idx[k]] || b_last[k] !== int'(k == e_idx.size() - 1)) begin
                failures++;
                $display("FAIL rmid_beat%0d: got idx=%0d cnt=%0d last=%0d want idx=%0d cnt=%0d",
                         k, b_idx[k], b_cnt[k], b_last[k], e_idx[k], cnts[e_idx[k]]);
            end
        end
        checks++; if (total_covered !== TW'(8)) begin failures++; $display("FAIL rmid_total2: got %0d want 8", total_covered); end
        checks++; if (cond_covered !== TW'(3)) begin failures++; $display("FAIL rmid_cond2: got %0d want 3", cond_covered); end
    endtask

    task automatic test_clear();
        load_counts();
        run_readout(0, 4, 1'b0, 1'b0);
        checks++; if (done_cyc !== exp_done_full()) begin failures++; $display("FAIL clr_done_cyc: got %0d want %0d", done_cyc, exp_done_full()); end
        checks++; if (clr_n !== 1) begin failures++; $display("FAIL clr_count: got %0d pulses want 1", clr_n); end
        checks++; if (clr_first !== exp_done_full() + 1) begin failures++; $display("FAIL clr_when: got cycle %0d want %0d", clr_first, exp_done_full() + 1); end
        cnts = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        load_counts();
        run_readout(0, -1, 1'b0, 1'b0);
        checks++; if (b_idx.size() !== e_idx.size()) begin failures++; $display("FAIL zero_nbeats: got %0d want %0d", b_idx.size(), e_idx.size()); end
        for (int k = 0; k < b_idx.size() && k < e_idx.size(); k++) begin
            checks++;
            if (b_idx[k] !== e_idx[k] || b_cnt[k] !== 0 || b_cov[k] !== 0) begin
                failures++;
                $display("FAIL zero_beat%0d: got idx=%0d cnt=%0d cov=%0d want idx=%0d cnt=0 cov=0", k, b_idx[k], b_cnt[k], b_cov[k], e_idx[k]);
            end
        end
        checks++; if (done_cyc !== exp_done_full()) begin failures++; $display("FAIL zero_done_cyc: got %0d want %0d", done_cyc, exp_done_full()); end
        checks++; if (total_covered !== '0) begin failures++; $display("FAIL zero_total: got %0d want 0", total_covered); end
        checks++; if (cond_covered !== '0) begin failures++; $display("FAIL zero_cond: got %0d want 0", cond_covered); end
        checks++; if (clr_n !== 0) begin failures++; $display("FAIL zero_no_clr: got %0d pulses want 0", clr_n); end
    endtask

    initial begin
        reset       = 1'b0;
        cnt_vec     = '0;
        is_cond_vec = 13'b1_1111_0000_0000;
        start       = 1'b0;
        clear_req   = 1'b0;
        out_ready   = 1'b1;
        test_reset();
        test_basic();
        test_idle_clear();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cov_readout.md
Name: cov_readout

Overview:
- Hardware reader for toggle/bin-expression coverage counters produced by the coverage instrumentation.
- Takes a snapshot of all per-point hit counters when a request is accepted.
- Streams each point's index and count over a valid/ready interface, then presents summary totals (covered points, covered condition points).
- Also issues the clear pulse back to the instrumentation, the hardware counterpart of resetCoverage.

Parameters:
- NUM_POINTS, 13, number of coverage points (nets + vars + bin-exprs).
- CNT_W, 32, width of each hit counter.
- IDX_W, $clog2(NUM_POINTS), width of point index.
- TOT_W, $clog2(NUM_POINTS+1), width of summary totals.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- cnt_vec  in  NUM_POINTS*CNT_W  packed hit counters; point i at [i*CNT_W +: CNT_W].
- is_cond_vec  in  NUM_POINTS  1 = point i is a bin-expr (condition) point.
- start  in  1  readout request; accepted only in IDLE.
- clear_req  in  1  request to clear instrumentation counters.
- busy  out  1  high in SNAP/STREAM/DONE.
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream consumer ready.
- out_idx  out  IDX_W  point index of current beat.
- out_count  out  CNT_W  snapshotted count of current beat.
- out_covered  out  1  out_count >= 1.
- out_last  out  1  final beat of readout.
- done  out  1  one-cycle pulse, summary valid.
- total_covered  out  TOT_W  number of points with count >= 1.
- cond_covered  out  TOT_W  number of condition points with count >= 1.
- clear_pulse  out  1  one-cycle clear strobe to instrumentation.

Behaviour:
- Reset (reset==0, async): state IDLE. All outputs 0; pending-clear flag 0; snapshot regs 0.
- FSM IDLE -> SNAP -> STREAM -> DONE -> IDLE.
- IDLE, start==1: go to SNAP. Totals accumulators cleared.
- SNAP (1 cycle): all NUM_POINTS counters and is_cond_vec registered into snapshot. Later cnt_vec changes do not affect the stream. Go to STREAM with idx=0.
- STREAM:
  - out_valid=1; out_idx/out_count/out_covered/out_last are registered from snapshot[idx].
  - While out_valid && !out_ready, all stream outputs hold stable.
  - Transfer on out_valid && out_ready: the accumulators add out_covered (total) and out_covered&&is_cond (cond).
  - After transfer, idx++. The next beat is presented the following cycle; back-to-back beats at full rate.
  - out_last=1 only when idx==NUM_POINTS-1. A transfer with out_last goes to DONE.
- DONE (1 cycle):
  - out_valid=0, done=1.
  - total_covered/cond_covered are updated with the final accumulator values. They hold until the next DONE or reset.
  - Go to IDLE.
- Latency: start high at cycle T -> first out_valid at T+2. With ready always 1, done at T+2+NUM_POINTS.
- start while busy: ignored, no queuing.
- clear_req in IDLE with no start: clear_pulse=1 next cycle. Totals unchanged.
- clear_req while busy, or coincident with an accepted start: latched pending. clear_pulse is issued the cycle after DONE (first IDLE cycle). Multiple requests merge into one pulse.
- start in the cycle clear_pulse is high: accepted normally. The snapshot is taken the next cycle, after instrumentation has cleared.
- Reset mid-stream: out_valid drops immediately (async). The consumer must discard the partial readout. The pending clear is lost.
- Accumulators are TOT_W wide and cannot overflow (max NUM_POINTS).

Optional Feature:
- Macro: COV_READOUT_SKIP_MISSED_EN.
- Defined: beats whose snapshot count==0 are skipped, with no beat and no cycle spent per skipped point.
  - Indices of emitted beats stay true point indices and are strictly ascending.
  - out_last marks the last covered point.
  - If no point is covered, go STREAM -> DONE with no beats and totals 0.
  - Totals are identical to the non-skip mode.
- Undefined: every point emits exactly one beat, NUM_POINTS beats per readout.

Test Plan:
- NUM_POINTS=13, points 8..12 cond, counts {5,0,3,0,1,1,0,2,7,0,4,0,9}, ready=1, start pulse -> 13 beats idx 0..12 with matching counts, out_last on idx 12, done at start+15, total_covered=8, cond_covered=3.
- Same counts, out_ready toggles 1,0,0,1 repeating -> outputs stable during stalls, same 13 beats in order, same totals; cnt_vec changed after SNAP does not alter beats.
- clear_req asserted at stream beat 4 -> no clear_pulse until DONE; exactly one clear_pulse the cycle after done; second start after clear with all counts 0 -> total_covered=0.
- start asserted mid-stream and in DONE -> ignored, exactly 13 beats, single done pulse.
- reset driven low at beat 6 -> out_valid, busy, totals, clear_pulse all 0 asynchronously; new start after release -> full correct readout.
- With COV_READOUT_SKIP_MISSED_EN, counts as test 1 -> 8 beats idx {0,2,4,5,7,8,10,12}, out_last on idx 12, totals 8/3; all-zero counts -> done at start+3, no beats.
